// File: rtl/config_serializer.sv
// config_serializer
//   Pops 36-bit configuration words from a standard-mode (1-cycle read
//   latency) FIFO and shifts each one out MSB-first on LANES parallel serial
//   lines with a generated serial clock. After the word carrying the "last"
//   flag (fifo_q[FIFO_WIDTH-1]) it pulses latch, then pulses done.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   start       1-cycle frame start, honoured only in IDLE
//   abort       level, returns the block to IDLE on the next edge
//   fifo_empty  FIFO empty flag
//   fifo_q      FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  FIFO pop strobe
//   sdo         serial data, one bit per lane
//   sck         serial clock, chip samples sdo on its rising edge
//   latch       configuration load strobe
//   busy        high outside IDLE
//   done        1-cycle frame completion pulse
//   word_count  words shifted in the current / last frame (saturating)

// One serial lane: holds its slice of the word and presents the current bit.
module config_serializer_lane #(
  parameter int BITS_PER_LANE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     shift,
  input  logic                     clear,
  input  logic [BITS_PER_LANE-1:0] din,
  output logic                     sdo
);
  logic [BITS_PER_LANE-1:0] sr;
  logic [BITS_PER_LANE-1:0] sr_sh;

  assign sr_sh = sr << 1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr  <= '0;
      sdo <= 1'b0;
    end else if (clear) begin
      sdo <= 1'b0;
    end else if (load) begin
      sr  <= din;
      sdo <= din[BITS_PER_LANE-1];
    end else if (shift) begin
      sr  <= sr_sh;
      sdo <= sr_sh[BITS_PER_LANE-1];
    end
  end
endmodule

module config_serializer #(
  parameter int FIFO_WIDTH    = 36,
  parameter int LANES         = 8,
  parameter int BITS_PER_LANE = 4,
  parameter int HALF_PERIOD   = 2,
  parameter int LATCH_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_q,
  output logic                  fifo_rd_en,
  output logic [LANES-1:0]      sdo,
  output logic                  sck,
  output logic                  latch,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           word_count
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int PH_W  = $clog2(2*HALF_PERIOD + 1);
  localparam int BIT_W = $clog2(BITS_PER_LANE + 1);
  localparam int LAT_W = $clog2(LATCH_CYCLES + 1);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2*HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_LANE - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

  logic [2:0]       state;
  logic             wait_ph;   // WAIT spans the pop cycle and the data cycle
  logic [PH_W-1:0]  ph_cnt;
  logic [BIT_W-1:0] bit_idx;
  logic [LAT_W-1:0] lat_cnt;
  logic             last_q;

  logic [LANES-1:0][BITS_PER_LANE-1:0] lane_din;
  logic ph_last, bit_last;
  logic ln_load, ln_shift, ln_clear;

  // Flag and lane slices are the only fields consumed; the rest is spare.
  logic unused_fifo_bits;
  assign unused_fifo_bits = &{1'b0, fifo_q};

  assign ph_last  = (ph_cnt == PH_LAST);
  assign bit_last = (bit_idx == BIT_LAST);

  assign ln_load  = !abort && (state == S_WAIT) && wait_ph;
  assign ln_shift = !abort && (state == S_SHIFT) && ph_last && !bit_last;
  // sdo drops on abort and while latching; it holds across a REQ stall.
  assign ln_clear = abort || ((state == S_SHIFT) && ph_last && bit_last && last_q);

  assign busy  = (state != S_IDLE);
  assign latch = (state == S_LATCH);
  assign done  = (state == S_DONE);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_din[k] = fifo_q[k*BITS_PER_LANE +: BITS_PER_LANE];
    config_serializer_lane #(.BITS_PER_LANE(BITS_PER_LANE)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (ln_load),
      .shift (ln_shift),
      .clear (ln_clear),
      .din   (lane_din[k]),
      .sdo   (sdo[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      fifo_rd_en <= 1'b0;
      sck        <= 1'b0;
      wait_ph    <= 1'b0;
      ph_cnt     <= '0;
      bit_idx    <= '0;
      lat_cnt    <= '0;
      last_q     <= 1'b0;
      word_count <= '0;
    end else if (abort) begin
      state      <= S_IDLE;
      fifo_rd_en <= 1'b0;
      sck        <= 1'b0;
      wait_ph    <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            word_count <= '0;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          sck <= 1'b0;
          if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
            wait_ph    <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!wait_ph) begin
            wait_ph <= 1'b1;
          end else begin
            last_q  <= fifo_q[FIFO_WIDTH-1];
            ph_cnt  <= '0;
            bit_idx <= '0;
            sck     <= 1'b0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (ph_last) begin
            ph_cnt <= '0;
            sck    <= 1'b0;
            if (bit_last) begin
              if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
              lat_cnt <= '0;
              state   <= last_q ? S_LATCH : S_REQ;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
            // sck rises once the low half-period has elapsed
            sck    <= (ph_cnt >= PH_HALF);
          end
        end
        S_LATCH: begin
          sck <= 1'b0;
          if (lat_cnt == LAT_LAST) state <= S_DONE;
          else                     lat_cnt <= lat_cnt + LAT_W'(1);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_config_serializer.sv
module tb_config_serializer;
  localparam int FW = 36, LN = 8, BPL = 4, HP = 2, LC = 4;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic fifo_empty, fifo_rd_en, sck, latch, busy, done;
  logic [FW-1:0] fifo_q = '0;
  logic [LN-1:0] sdo;
  logic [15:0] word_count;

  int total = 0, passed = 0;

  config_serializer #(.FIFO_WIDTH(FW), .LANES(LN), .BITS_PER_LANE(BPL),
                      .HALF_PERIOD(HP), .LATCH_CYCLES(LC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rd_en(fifo_rd_en),
    .sdo(sdo), .sck(sck), .latch(latch), .busy(busy), .done(done),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Standard-mode FIFO: data appears the cycle after the pop strobe.
  logic [FW-1:0] mem [0:63];
  int wr_ptr = 0, rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en && rd_ptr != wr_ptr) begin
      fifo_q <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor, sampled 1 time unit after each rising edge.
  int cyc = 0;
  int rd_cnt, first_rd_cyc, latch_pulses, latch_len, done_cnt, done_cyc, last_latch_cyc, viol;
  logic prev_sck = 1'b0, prev_latch = 1'b0;
  logic [LN-1:0] prev_sdo = '0;
  logic [LN-1:0] rise_sdo[$];
  int rise_cyc[$];
  logic [LN-1:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      if (fifo_rd_en) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (fifo_empty) viol++;
      end
      if (sck && !prev_sck) begin
        rise_sdo.push_back(sdo);
        rise_cyc.push_back(cyc);
      end
      if (sck && !busy) viol++;
      if (sck && sdo !== prev_sdo) viol++;
      if (latch && !prev_latch) latch_pulses++;
      if (latch) begin
        latch_len++;
        last_latch_cyc = cyc;
        if (sdo !== '0 || sck) viol++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_sck = sck; prev_latch = latch; prev_sdo = sdo;
  end

  task automatic clear_mon();
    rd_cnt = 0; first_rd_cyc = -1; latch_pulses = 0; latch_len = 0;
    done_cnt = 0; done_cyc = -1; last_latch_cyc = -1; viol = 0;
    rise_sdo.delete(); rise_cyc.delete(); exp_q.delete();
  endtask

  task automatic push_word(input logic [FW-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  // Reference: lane k carries w[k*BPL+BPL-1 : k*BPL], MSB first.
  task automatic expect_word(input logic [FW-1:0] w);
    logic [LN-1:0] v;
    for (int j = 0; j < BPL; j++) begin
      for (int k = 0; k < LN; k++) v[k] = w[k*BPL + BPL-1 - j];
      exp_q.push_back(v);
    end
  endtask

  function automatic logic [FW-1:0] rand_word(input logic last);
    return {last, 3'($urandom), 32'($urandom)};
  endfunction

  task automatic pulse_start(output int t0);
    @(negedge clk); start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    total++;
    if (done_cnt == 0) $display("FAIL wait_done: timeout after %0d cycles, done never seen", budget);
    else passed++;
  endtask

  task automatic check_stream(input string name);
    int bad = 0;
    total++;
    if (rise_sdo.size() != exp_q.size()) begin
      $display("FAIL %s_len: got %0d sck rises, expected %0d", name, rise_sdo.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (rise_sdo[i] !== exp_q[i]) bad++;
      if (bad != 0) $display("FAIL %s_bits: %0d of %0d bit slots wrong", name, bad, exp_q.size());
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1;
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({fifo_rd_en, sdo, sck, latch, busy, done, word_count} !== '0)
        $display("FAIL reset_outputs: got rd=%b sdo=%h sck=%b latch=%b busy=%b done=%b wc=%0d, expected all 0",
                 fifo_rd_en, sdo, sck, latch, busy, done, word_count);
      else passed++;
    end
    start = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || rd_cnt != 0) $display("FAIL reset_idle: got busy=%b rd=%0d, expected 0/0", busy, rd_cnt);
    else passed++;
  endtask

  task automatic test_single_word();
    logic [FW-1:0] w = 36'h8_FEDCBA98;
    logic [3:0] l0, l7;
    int t0, bad;
    clear_mon();
    push_word(w); expect_word(w);
    pulse_start(t0);
    while (cyc < t0 + 4) @(negedge clk);
    total++;
    if (sdo !== exp_q[0]) $display("FAIL single_first_sdo: got %b expected %b", sdo, exp_q[0]);
    else passed++;
    wait_done(200);
    total++;
    if (first_rd_cyc - t0 != 2) $display("FAIL single_rd_cycle: got %0d expected 2", first_rd_cyc - t0);
    else passed++;
    check_stream("single_stream");
    if (rise_sdo.size() == 4) begin
      for (int j = 0; j < 4; j++) begin l0[3-j] = rise_sdo[j][0]; l7[3-j] = rise_sdo[j][7]; end
      total++;
      if (l0 !== 4'b1000 || l7 !== 4'b1111) $display("FAIL single_lanes: got lane0=%b lane7=%b expected 1000/1111", l0, l7);
      else passed++;
      bad = 0;
      for (int j = 1; j < 4; j++) if (rise_cyc[j] - rise_cyc[j-1] != 2*HP) bad++;
      total++;
      if (rise_cyc[0] - t0 != 4 + HP || bad != 0)
        $display("FAIL single_sck_timing: first rise at %0d (expected %0d), %0d bad spacings", rise_cyc[0] - t0, 4 + HP, bad);
      else passed++;
    end
    total++;
    if (latch_pulses != 1 || latch_len != LC) $display("FAIL single_latch: got %0d pulses len %0d, expected 1 len %0d", latch_pulses, latch_len, LC);
    else passed++;
    total++;
    if (done_cnt != 1 || done_cyc - t0 != 4 + BPL*2*HP + LC || done_cyc != last_latch_cyc + 1)
      $display("FAIL single_done: got %0d pulses at %0d, expected 1 at %0d", done_cnt, done_cyc - t0, 4 + BPL*2*HP + LC);
    else passed++;
    total++;
    if (word_count !== 16'd1 || rd_cnt != 1 || viol != 0 || busy !== 1'b0)
      $display("FAIL single_end: got wc=%0d rd=%0d viol=%0d busy=%b, expected 1/1/0/0", word_count, rd_cnt, viol, busy);
    else passed++;
  endtask

  task automatic test_multi_word();
    logic [FW-1:0] w;
    int t0;
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      w = rand_word(i == 2);
      push_word(w); expect_word(w);
    end
    pulse_start(t0);
    wait_done(400);
    check_stream("multi_stream");
    total++;
    if (rd_cnt != 3 || latch_pulses != 1 || done_cnt != 1 || word_count !== 16'd3 || viol != 0)
      $display("FAIL multi_counts: got rd=%0d latch=%0d done=%0d wc=%0d viol=%0d, expected 3/1/1/3/0",
               rd_cnt, latch_pulses, done_cnt, word_count, viol);
    else passed++;
  endtask

  task automatic test_stall();
    logic [FW-1:0] w1 = rand_word(1'b0), w2 = rand_word(1'b1);
    int t0, sck_hi = 0, idle = 0;
    clear_mon();
    push_word(w1); expect_word(w1); expect_word(w2);
    pulse_start(t0);
    while (cyc < t0 + 30) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sck) sck_hi++;
      if (!busy) idle++;
    end
    total++;
    if (sck_hi != 0 || idle != 0 || rd_cnt != 1 || rise_sdo.size() != BPL)
      $display("FAIL stall_hold: got sck_hi=%0d idle=%0d rd=%0d rises=%0d, expected 0/0/1/%0d", sck_hi, idle, rd_cnt, rise_sdo.size(), BPL);
    else passed++;
    total++;
    if (sdo !== exp_q[BPL-1]) $display("FAIL stall_sdo_held: got %b expected %b", sdo, exp_q[BPL-1]);
    else passed++;
    push_word(w2);
    wait_done(200);
    check_stream("stall_stream");
    total++;
    if (done_cnt != 1 || word_count !== 16'd2 || rd_cnt != 2 || viol != 0)
      $display("FAIL stall_end: got done=%0d wc=%0d rd=%0d viol=%0d, expected 1/2/2/0", done_cnt, word_count, rd_cnt, viol);
    else passed++;
  endtask

  task automatic test_abort();
    logic [FW-1:0] w = rand_word(1'b1);
    int t0, rd0;
    clear_mon();
    push_word(w);
    pulse_start(t0);
    while (cyc < t0 + 4 + 2*HP + 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || sck !== 1'b0 || sdo !== '0 || fifo_rd_en !== 1'b0)
      $display("FAIL abort_outputs: got busy=%b sck=%b sdo=%h rd=%b, expected all 0", busy, sck, sdo, fifo_rd_en);
    else passed++;
    abort = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (latch_pulses != 0 || done_cnt != 0 || word_count !== 16'd0 || busy !== 1'b0)
      $display("FAIL abort_after: got latch=%0d done=%0d wc=%0d busy=%b, expected 0/0/0/0", latch_pulses, done_cnt, word_count, busy);
    else passed++;
    // start and abort together in IDLE: abort wins
    w = rand_word(1'b1);
    push_word(w);
    rd0 = rd_cnt;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0 || rd_cnt != rd0) $display("FAIL abort_start_idle: got busy=%b rd=%0d, expected 0/%0d", busy, rd_cnt, rd0);
    else passed++;
    // recovery: the pending word forms a normal frame
    clear_mon(); expect_word(w);
    pulse_start(t0);
    wait_done(200);
    check_stream("abort_recover_stream");
    total++;
    if (word_count !== 16'd1 || latch_pulses != 1) $display("FAIL abort_recover: got wc=%0d latch=%0d, expected 1/1", word_count, latch_pulses);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] w1 = rand_word(1'b0), w2 = rand_word(1'b1), w3 = rand_word(1'b1);
    int t0;
    clear_mon();
    push_word(w1); push_word(w2); expect_word(w1); expect_word(w2);
    pulse_start(t0);
    while (cyc < t0 + 10) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    while (cyc < t0 + 30) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(300);
    check_stream("b2b_stream");
    total++;
    if (rd_cnt != 2 || done_cnt != 1 || latch_pulses != 1 || word_count !== 16'd2)
      $display("FAIL b2b_ignore_start: got rd=%0d done=%0d latch=%0d wc=%0d, expected 2/1/1/2", rd_cnt, done_cnt, latch_pulses, word_count);
    else passed++;
    clear_mon();
    push_word(w3); expect_word(w3);
    pulse_start(t0);
    while (cyc < t0 + 2) @(negedge clk);
    total++;
    if (word_count !== 16'd0) $display("FAIL b2b_wc_clear: got %0d expected 0", word_count);
    else passed++;
    wait_done(200);
    check_stream("b2b_second_stream");
    total++;
    if (word_count !== 16'd1 || done_cnt != 1 || viol != 0)
      $display("FAIL b2b_second: got wc=%0d done=%0d viol=%0d, expected 1/1/0", word_count, done_cnt, viol);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_multi_word();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
